// File: rtl/arb_client_pkg.sv
// rtl/arb_client_pkg.sv - shared state type and default parameters for the arbiter requester agent
package arb_client_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_XFER,
    ST_GAP
  } state_t;

  localparam int DEF_LEN_W   = 4;
  localparam int DEF_TIMEOUT = 15;
  localparam int DEF_GAP     = 1;

endpackage

// File: rtl/arb_client_timer.sv
// rtl/arb_client_timer.sv - loadable down-counter with zero flag, shared by grant watchdog and release gap
module arb_client_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Saturates at zero so a held decrement never wraps into a false expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/arb_client.sv
// rtl/arb_client.sv - requester-side agent: raises req for a burst, counts granted beats, enforces release gap
module arb_client
  import arb_client_pkg::*;
#(
  parameter int LEN_W   = DEF_LEN_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int GAP     = DEF_GAP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             req,
  input  logic             gnt,
  output logic             beat_valid,
  output logic             beat_last,
  output logic             done,
  output logic             timeout,
  output logic             busy
);

  localparam int TMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t           state_q;
  logic             req_q;
  logic             done_q;
  logic             timeout_q;
  logic [LEN_W-1:0] remaining_q;

  logic             accept;
  logic             wd_fire;
  logic             tmr_load;
  logic [TW-1:0]    tmr_load_val;
  logic             tmr_dec;
  logic             tmr_zero;

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign beat_valid = ((state_q == ST_WAIT) || (state_q == ST_XFER)) && gnt;
  assign beat_last  = beat_valid && (remaining_q == '0);

  // A grant on the expiry cycle takes priority, so the watchdog is gated by !gnt.
  assign wd_fire = (TIMEOUT != 0) && (state_q == ST_WAIT) && !gnt && tmr_zero;

  // Timer is loaded with TIMEOUT-1 on accept and GAP-1 on entry to the gap.
  assign tmr_load     = accept || beat_last || wd_fire;
  assign tmr_load_val = accept ? TW'(TIMEOUT - 1) : TW'(GAP - 1);
  assign tmr_dec      = ((state_q == ST_WAIT) && !gnt) || (state_q == ST_GAP);

  arb_client_timer #(
    .W (TW)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      remaining_q <= '0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            remaining_q <= cmd_len;
            req_q       <= 1'b1;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT, ST_XFER: begin
          if (beat_valid) begin
            if (beat_last) begin
              req_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_GAP;
            end else begin
              remaining_q <= remaining_q - 1'b1;
              state_q     <= ST_XFER;
            end
          end else if (wd_fire) begin
            req_q     <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_zero) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req     = req_q;
  assign done    = done_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_arb_client.sv
// tb/tb_arb_client.sv - scoreboard bench for arb_client with directed, random and two-client arbiter traffic
module tb_arb_client;

  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 15;
  localparam int GAP     = 1;

  // Scoreboard event codes: 0 beat, 1 last beat, 2 done, 3 timeout.
  localparam int EV_BEAT = 0;
  localparam int EV_LAST = 1;
  localparam int EV_DONE = 2;
  localparam int EV_TO   = 3;

  logic             clock;
  logic             reset;
  logic             cv0, cv1;
  logic [LEN_W-1:0] cl0, cl1;
  logic             rdy0, rdy1;
  logic             req0, req1;
  logic             gnt0, gnt1;
  logic             bv0, bv1, bl0, bl1;
  logic             dn0, dn1, to0, to1;
  logic             busy0, busy1;
  logic             tb_gnt;
  logic             arb_mode;
  logic [1:0]       arb_g;
  logic             arb_last;

  int errors = 0;
  int checks = 0;
  int exp_q0[$];
  int exp_q1[$];
  int gseq[256];

  assign gnt0 = arb_mode ? arb_g[0] : tb_gnt;
  assign gnt1 = arb_mode ? arb_g[1] : 1'b0;

  arb_client #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut0 (
    .clock(clock), .reset(reset), .cmd_valid(cv0), .cmd_len(cl0), .cmd_ready(rdy0),
    .req(req0), .gnt(gnt0), .beat_valid(bv0), .beat_last(bl0), .done(dn0),
    .timeout(to0), .busy(busy0)
  );

  arb_client #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut1 (
    .clock(clock), .reset(reset), .cmd_valid(cv1), .cmd_len(cl1), .cmd_ready(rdy1),
    .req(req1), .gnt(gnt1), .beat_valid(bv1), .beat_last(bl1), .done(dn1),
    .timeout(to1), .busy(busy1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Registered-grant arbiter: holds the owner while its req stays high, otherwise alternates.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      arb_g    <= 2'b00;
      arb_last <= 1'b1;
    end else if (arb_g[0] && req0) begin
      arb_g <= 2'b01;
    end else if (arb_g[1] && req1) begin
      arb_g <= 2'b10;
    end else if (req0 && (!req1 || arb_last)) begin
      arb_g    <= 2'b01;
      arb_last <= 1'b0;
    end else if (req1) begin
      arb_g    <= 2'b10;
      arb_last <= 1'b1;
    end else begin
      arb_g <= 2'b00;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic pop_check(input int c, input int got);
    int e;
    checks++;
    if ((c == 0 && exp_q0.size() == 0) || (c == 1 && exp_q1.size() == 0)) begin
      errors++;
      $display("FAIL event_c%0d: got event %0d expected none", c, got);
    end else begin
      if (c == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      if (e != got) begin
        errors++;
        $display("FAIL event_c%0d: got event %0d expected %0d", c, got, e);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bv0) pop_check(0, bl0 ? EV_LAST : EV_BEAT);
        else if (bl0) begin checks++; errors++; $display("FAIL last_qual_c0: got beat_last=1 expected 0"); end
        if (dn0) pop_check(0, EV_DONE);
        if (to0) pop_check(0, EV_TO);
        if (bv1) pop_check(1, bl1 ? EV_LAST : EV_BEAT);
        else if (bl1) begin checks++; errors++; $display("FAIL last_qual_c1: got beat_last=1 expected 0"); end
        if (dn1) pop_check(1, EV_DONE);
        if (to1) pop_check(1, EV_TO);
        if (arb_mode) chk("both_beat", int'(bv0 && bv1), 0);
      end
    end
  end

  task automatic fill_seq(input int zeros);
    for (int i = 0; i < 256; i++) gseq[i] = (i < zeros) ? 0 : 1;
  endtask

  // Reference model: count grants as beats until len+1; TIMEOUT grantless cycles before the first beat abandon.
  task automatic run_txn(input int len, input bit hold);
    int nc, beats, waited, n;
    bit ended;
    nc = 0; beats = 0; waited = 0; ended = 0;
    for (int i = 0; i < 256 && !ended; i++) begin
      nc++;
      if (gseq[i] != 0) begin
        beats++;
        if (beats == len + 1) begin
          exp_q0.push_back(EV_LAST);
          exp_q0.push_back(EV_DONE);
          ended = 1;
        end else begin
          exp_q0.push_back(EV_BEAT);
        end
      end else if (beats == 0) begin
        waited++;
        if (waited == TIMEOUT) begin
          exp_q0.push_back(EV_TO);
          ended = 1;
        end
      end
    end
    n = 0;
    while (!rdy0 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk("ready_wait", int'(rdy0), 1);
    tb_gnt = 1'($urandom % 2);
    cv0 = 1'b1;
    cl0 = LEN_W'(len);
    @(posedge clock); #1;
    if (!hold) cv0 = 1'b0;
    chk("req_raised", int'(req0), 1);
    for (int i = 0; i < nc; i++) begin
      tb_gnt = gseq[i][0];
      @(posedge clock); #1;
      chk((i < nc - 1) ? "req_held" : "req_dropped", int'(req0), (i < nc - 1) ? 1 : 0);
    end
    tb_gnt = 1'($urandom % 2);
    chk("not_ready_in_gap", int'(rdy0), 0);
    repeat (GAP) begin
      @(posedge clock); #1;
    end
    tb_gnt = 1'b0;
    chk("ready_after_gap", int'(rdy0), 1);
    chk("queue_drained", exp_q0.size(), 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; cv0 = 1'b1; cl0 = '0; cv1 = 1'b0; cl1 = '0;
    tb_gnt = 1'b1; arb_mode = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", int'(rdy0), 1);
    chk("rst_req", int'(req0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_beat_valid", int'(bv0), 0);
    chk("rst_beat_last", int'(bl0), 0);
    chk("rst_done", int'(dn0), 0);
    chk("rst_timeout", int'(to0), 0);
    cv0 = 1'b0; tb_gnt = 1'b0; reset = 1'b0;
    @(posedge clock); #1;
    chk("idle_after_reset", int'(busy0), 0);

    fill_seq(1);  run_txn(0, 0);
    fill_seq(0);  gseq[2] = 0; gseq[3] = 0; run_txn(3, 0);
    fill_seq(256); run_txn(2, 0);
    fill_seq(14); run_txn(2, 0);
    fill_seq(0);  run_txn(15, 0);
    fill_seq(0);  run_txn(0, 1);
    fill_seq(2);  run_txn(4, 0);

    // Reset during the second beat of a four-beat burst.
    exp_q0.push_back(EV_BEAT);
    cv0 = 1'b1; cl0 = 4'd3;
    @(posedge clock); #1;
    cv0 = 1'b0; tb_gnt = 1'b1;
    @(posedge clock); #1;
    #1 reset = 1'b1;
    #1;
    chk("async_req_drop", int'(req0), 0);
    chk("async_busy_drop", int'(busy0), 0);
    @(posedge clock); #1;
    reset = 1'b0; tb_gnt = 1'b0;
    chk("ready_after_reset", int'(rdy0), 1);
    chk("reset_queue_drained", exp_q0.size(), 0);
    fill_seq(0);  run_txn(1, 0);

    for (int t = 0; t < 25; t++) begin
      int delay;
      delay = (($urandom % 4) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 3));
      for (int i = 0; i < 256; i++)
        gseq[i] = (i < delay) ? 0 : (i > 150) ? 1 : ((($urandom % 4) != 0) ? 1 : 0);
      run_txn(int'($urandom_range(0, 15)), 1'($urandom % 2));
    end
    cv0 = 1'b0;
    @(posedge clock); #1;
    n = 0;
    while (busy0 && n < 300) begin
      if (gseq[0] == 0) tb_gnt = 1'b0;
      tb_gnt = 1'b1;
      @(posedge clock); #1;
      n++;
    end
    tb_gnt = 1'b0;
    // A held cmd_valid on the last random txn may have started one more burst; drain it.
    repeat (3) @(posedge clock);
    #1;
    exp_q0.delete();

    arb_mode = 1'b1;
    @(posedge clock); #1;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin exp_q0.push_back(EV_BEAT); exp_q0.push_back(EV_BEAT); exp_q0.push_back(EV_LAST); exp_q0.push_back(EV_DONE); end
      else        begin exp_q1.push_back(EV_BEAT); exp_q1.push_back(EV_BEAT); exp_q1.push_back(EV_LAST); exp_q1.push_back(EV_DONE); end
    end
    chk("integ_ready0", int'(rdy0), 1);
    chk("integ_ready1", int'(rdy1), 1);
    cv0 = 1'b1; cv1 = 1'b1; cl0 = 4'd2; cl1 = 4'd2;
    @(posedge clock); #1;
    cv0 = 1'b0; cv1 = 1'b0;
    n = 0;
    while ((busy0 || busy1) && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    chk("integ_finish", int'(busy0 || busy1), 0);
    chk("integ_queue0", exp_q0.size(), 0);
    chk("integ_queue1", exp_q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/arb_client.md
Name: arb_client

Overview:
- Requester-side agent for the two-way req/gnt arbiter.
- Accepts a burst command and raises `req`, then waits for `gnt` and counts granted beats.
- Drops `req` after the last beat and enforces a release gap so the arbiter can rotate.
- One instance sits on each arbiter port (`req_0`/`gnt_0`, `req_1`/`gnt_1`). Includes a grant-wait watchdog.

Parameters:
- LEN_W, 4, width of `cmd_len`; a burst is `cmd_len + 1` beats (1..2^LEN_W).
- TIMEOUT, 15, max cycles in WAIT with `gnt` low before abandoning; 0 disables the watchdog.
- GAP, 1, cycles `req` is held low after a burst before the next command is accepted; must be ≥ 1.

Ports:
- clock, input, 1, single clock; all state updates on posedge.
- reset, input, 1, asynchronous active-high reset.
- cmd_valid, input, 1, command present.
- cmd_len, input, LEN_W, beats minus one.
- cmd_ready, output, 1, block can accept a command.
- req, output, 1, registered request to the arbiter.
- gnt, input, 1, grant from the arbiter.
- beat_valid, output, 1, this cycle is a granted beat.
- beat_last, output, 1, final beat of the burst (qualifies `beat_valid`).
- done, output, 1, one-cycle pulse after a burst completes.
- timeout, output, 1, one-cycle pulse when the watchdog fires.
- busy, output, 1, high in any state except IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Ports are named `clock` and `reset`.
- Reset values while `reset` is high:
  - state IDLE; `req`, `done`, `timeout` = 0.
  - internal counters = 0.
  - `beat_valid`, `beat_last`, `busy` = 0; `cmd_ready` = 1 (decoded from IDLE).
  - A `cmd_valid` while `reset` is high is not accepted.
- Reset mid-burst: `req` falls asynchronously; the partial burst is discarded; no `done` or `timeout` pulse.
- States: IDLE, WAIT, XFER, GAP.
- IDLE:
  - `cmd_ready` = 1.
  - On `cmd_valid && cmd_ready` at an edge: latch `remaining = cmd_len`, clear `wait_cnt`, go to WAIT, `req` = 1 from the next cycle.
- Beat definition: `beat_valid = (state is WAIT or XFER) && gnt`, combinational from `gnt`. `beat_last = beat_valid && remaining == 0`.
- WAIT (request raised, no grant yet):
  - `gnt` = 1: beat counted; go to XFER, or to GAP if it is the last beat.
  - `gnt` = 0: `wait_cnt` increments.
  - If TIMEOUT != 0 and `wait_cnt == TIMEOUT - 1` with `gnt` low: go to GAP with `req` = 0 and `timeout` pulsed for exactly one cycle (the first GAP cycle). `done` is not pulsed.
- XFER (granted at least once):
  - Each beat decrements `remaining`.
  - `gnt` dropping mid-burst (preemption) stalls: `req` stays 1, `beat_valid` = 0, `remaining` holds.
  - The watchdog does not run in XFER.
  - Last beat: go to GAP.
- GAP:
  - `req` = 0; `done` = 1 in the first GAP cycle only (unless entered by timeout).
  - Stays GAP cycles, then returns to IDLE.
- Latency, uncontended, with a registered-grant arbiter:
  - command accepted at edge 0;
  - `req` high after edge 0;
  - `gnt` high after edge 1;
  - beats in cycles 1..N;
  - `req` low and `done` high after edge N+1;
  - `cmd_ready` after edge N+1+GAP.
- Boundaries:
  - `cmd_len = 0` gives a single beat; WAIT→GAP directly.
  - `cmd_len = 2^LEN_W - 1` gives a maximum burst with no counter wrap.
  - `gnt` high while in IDLE or GAP is ignored (no beat).
  - `cmd_valid` held high through a burst is accepted again only on return to IDLE.
  - A grant arriving on the same edge the watchdog expires wins: it is counted as a beat and no timeout fires.

Decomposition:
- Package `arb_client_pkg`:
  - `state_t` enum {IDLE, WAIT, XFER, GAP};
  - default constants for LEN_W, TIMEOUT and GAP.
- Sub-module `arb_client_timer`:
  - loadable down-counter with a `zero` flag;
  - reused for the WAIT watchdog and the GAP hold;
  - the two uses never overlap, so one instance serves both.

Test Plan:
- Single beat: `cmd_len = 0`, `gnt` driven high 1 cycle after `req` → exactly one `beat_valid` with `beat_last`; `req` low next cycle; `done` pulses once; `cmd_ready` high GAP (1) cycles later.
- Burst with preemption: `cmd_len = 3`, `gnt` pattern 1,1,0,0,1,1 → 4 beats total; `req` stays high through the stall; `beat_last` on the 4th beat; one `done`.
- Timeout: `cmd_len = 2`, TIMEOUT = 15, `gnt` held 0 → `req` high 15 cycles then low; one `timeout` pulse; no `done`; IDLE after GAP.
- Grant-at-expiry race: `gnt` rises in the 15th WAIT cycle → counted as beat 1; no `timeout`; burst completes with 3 beats.
- Reset mid-burst: assert `reset` during beat 2 of a 4-beat burst → `req` = 0 immediately (asynchronous); no `done`; after release `cmd_ready` = 1 and a fresh `cmd_len = 1` completes with 2 beats.
- Integration: two `arb_client`s on the arbiter, both issued `cmd_len = 2` together → `gnt_0` serves client 0's 3 beats, the GAP releases it, client 1 then receives 3 beats; never both `beat_valid` in one cycle.
